opr1_sequencer: RTL and testbench
=================================

OPR1_SEQUENCER -- requirements
Module: opr1_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to execute IR as an operate group 1 microinstruction.
REQ-004 SHALL have port IR, input, 12 bits: instruction word, PDP-8 order (IR[11] = MSB).
REQ-005 SHALL have port ACI, input, 12 bits: accumulator value captured at start.
REQ-006 SHALL have port LI, input, 1 bit: link value captured at start.
REQ-007 SHALL have port ACO, output, 12 bits: registered accumulator result.
REQ-008 SHALL have port LO, output, 1 bit: registered link result.
REQ-009 SHALL have port busy, output, 1 bit: high in every non-IDLE state except DONE.
REQ-010 SHALL have port done, output, 1 bit: high for exactly one cycle, in DONE.
REQ-011 SHALL have port ROP, output, 3 bits: rotater opcode (001 swap, 010 left 1, 011 left 2, 100 right 1, 101 right 2, 000 pass).
REQ-012 SHALL have port RAI, output, 12 bits: rotater A input, equal to the internal AC register.
REQ-013 SHALL have port RLI, output, 1 bit: rotater L input, equal to the internal link register.
REQ-014 SHALL have port ROE, output, 1 bit: rotater output enable, high only in state ROT.
REQ-015 SHALL have port RAO, input, 12 bits: rotater A result.
REQ-016 SHALL have port RLO, input, 1 bit: rotater L result.

Function
REQ-017 SHALL implement states IDLE, CLR, CMP, INC, ROT, DONE.
REQ-018 SHALL, in IDLE with start=1, load ACI/LI into the AC/L registers and leave IDLE on the same edge.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 SHALL treat IR[11:8]!=1110 as a no-op: go from IDLE directly to DONE with AC/L unchanged.
REQ-021 SHALL decode the step enables as follows: CLA=IR[7], CLL=IR[6], CMA=IR[5], CML=IR[4], RAR=IR[3], RAL=IR[2], BSW=IR[1], IAC=IR[0].
REQ-022 SHALL, on the CLR exit edge: if CLA, AC<=0; if CLL, L<=0.
REQ-023 SHALL, on the CMP exit edge: if CMA, AC<=~AC; if CML, L<=~L.
REQ-024 SHALL, on the INC exit edge when IAC is set: compute the 13-bit sum {L,AC}+1, modulo 8192. Carry out of AC complements L (AC 7777 -> 0000, L toggles).
REQ-025 SHALL derive ROP from RAR/RAL/BSW: RAL->010; RAL+BSW->011; RAR->100; RAR+BSW->101; BSW alone->001; none->000; RAR and RAL both set->000.
REQ-026 SHALL, on the ROT exit edge, load AC<=RAO and L<=RLO.
REQ-027 SHALL visit the steps in the fixed order CLR, CMP, INC, ROT, then DONE.
REQ-028 SHALL transition from DONE to IDLE after one cycle; start present during DONE is ignored.
REQ-029 SHALL drive ACO/LO continuously from the AC/L registers; values hold until the next accepted start.

Reset
REQ-030 SHALL, on reset=1 at a clock edge in any state (including mid-operation), force state=IDLE, AC=0, L=0, busy=0, done=0.
REQ-031 SHALL give reset priority over start in the same cycle.

Configuration
REQ-032 SHALL support the macro OPR1_FASTSEQ_EN.
REQ-033 SHALL, when OPR1_FASTSEQ_EN is defined, skip any step whose enables are all clear; ROT counts as clear when ROP=000. A group 1 NOP (7000) reaches DONE directly from IDLE.
REQ-034 SHALL, when OPR1_FASTSEQ_EN is undefined, visit all four steps for a group 1 instruction, so done rises exactly 5 cycles after the start cycle.

Structure
REQ-035 SHALL place the state enum, the IR bit-index constants and the ROP encodings in a shared package, pdp8_pkg.
REQ-036 SHALL place the combinational IR decode (step enables and ROP) in one sub-module, opr1_decode. The rotater itself stays external and connects through the R* ports.

Verification
REQ-037 SHALL cover: IR=7001, ACI=7777, LI=0 -> ACO=0000, LO=1; without the macro, done 5 cycles after start.
REQ-038 SHALL cover: IR=7240, ACI=1234 -> ACO=7777, LO=LI.
REQ-039 SHALL cover: IR=7104, ACI=4000, LI=1 -> ACO=0000, LO=1; ROP=010 while ROE=1.
REQ-040 SHALL cover: IR=7012, ACI=0001, LI=0 -> ROP=101, ACO=4000, LO=0; then IR=7002, ACI=0077 -> ACO=7700.
REQ-041 SHALL cover: IR=7400 -> done the cycle after start, ACO=ACI. With the macro, IR=7000 -> done the cycle after start.
REQ-042 SHALL cover: reset asserted during INC -> next cycle IDLE, ACO=0000, busy=0, done never pulses. Start pulsed while busy -> ignored, result unaffected.

Source files
------------

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 operate group 1 definitions: sequencer states, IR bit positions,
// rotater opcodes and the decoded control bundle.
package pdp8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_CMP  = 3'd2,
    ST_INC  = 3'd3,
    ST_ROT  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam int IR_CLA = 7;
  localparam int IR_CLL = 6;
  localparam int IR_CMA = 5;
  localparam int IR_CML = 4;
  localparam int IR_RAR = 3;
  localparam int IR_RAL = 2;
  localparam int IR_BSW = 1;
  localparam int IR_IAC = 0;

  localparam logic [3:0] OPR1_GRP = 4'b1110;

  localparam logic [2:0] ROP_PASS = 3'b000;
  localparam logic [2:0] ROP_SWAP = 3'b001;
  localparam logic [2:0] ROP_RAL  = 3'b010;
  localparam logic [2:0] ROP_RTL  = 3'b011;
  localparam logic [2:0] ROP_RAR  = 3'b100;
  localparam logic [2:0] ROP_RTR  = 3'b101;

  typedef struct packed {
    logic       grp1;
    logic       cla;
    logic       cll;
    logic       cma;
    logic       cml;
    logic       iac;
    logic [2:0] rop;
  } opr1_ctl_t;

endpackage

// File: rtl/opr1_decode.sv
// Combinational decode of an operate group 1 instruction word into step
// enables and the rotater opcode.
module opr1_decode
  import pdp8_pkg::*;
(
  input  logic [11:0] i_ir,
  output opr1_ctl_t   o_ctl
);

  logic w_rar;
  logic w_ral;
  logic w_bsw;

  assign w_rar = i_ir[IR_RAR];
  assign w_ral = i_ir[IR_RAL];
  assign w_bsw = i_ir[IR_BSW];

  always_comb begin
    o_ctl      = '0;
    o_ctl.grp1 = (i_ir[11:8] == OPR1_GRP);
    o_ctl.cla  = i_ir[IR_CLA];
    o_ctl.cll  = i_ir[IR_CLL];
    o_ctl.cma  = i_ir[IR_CMA];
    o_ctl.cml  = i_ir[IR_CML];
    o_ctl.iac  = i_ir[IR_IAC];
    // Conflicting rotate directions collapse to a pass-through.
    if (w_rar && w_ral)
      o_ctl.rop = ROP_PASS;
    else if (w_ral)
      o_ctl.rop = w_bsw ? ROP_RTL : ROP_RAL;
    else if (w_rar)
      o_ctl.rop = w_bsw ? ROP_RTR : ROP_RAR;
    else if (w_bsw)
      o_ctl.rop = ROP_SWAP;
    else
      o_ctl.rop = ROP_PASS;
  end

endmodule

// File: rtl/opr1_sequencer.sv
// PDP-8 operate group 1 microsequencer (CLR, CMP, INC, ROT) driving an external
// rotater. Define OPR1_FASTSEQ_EN to skip steps whose enables are all clear.
module opr1_sequencer
  import pdp8_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] IR,
  input  logic [11:0] ACI,
  input  logic        LI,
  output logic [11:0] ACO,
  output logic        LO,
  output logic        busy,
  output logic        done,
  output logic [2:0]  ROP,
  output logic [11:0] RAI,
  output logic        RLI,
  output logic        ROE,
  input  logic [11:0] RAO,
  input  logic        RLO
);

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_ac;
  logic        r_l;
  logic [11:0] r_ir;
  logic [11:0] w_ir;
  opr1_ctl_t   w_ctl;
  logic        w_en_clr;
  logic        w_en_cmp;
  logic        w_en_inc;
  logic        w_en_rot;

  // In IDLE the live IR steers the first step; afterwards the captured copy.
  assign w_ir = (r_state == ST_IDLE) ? IR : r_ir;

  opr1_decode u_decode (
    .i_ir  (w_ir),
    .o_ctl (w_ctl)
  );

`ifdef OPR1_FASTSEQ_EN
  assign w_en_clr = w_ctl.cla | w_ctl.cll;
  assign w_en_cmp = w_ctl.cma | w_ctl.cml;
  assign w_en_inc = w_ctl.iac;
  assign w_en_rot = (w_ctl.rop != ROP_PASS);
`else
  assign w_en_clr = 1'b1;
  assign w_en_cmp = 1'b1;
  assign w_en_inc = 1'b1;
  assign w_en_rot = 1'b1;
`endif

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    ROE    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (!w_ctl.grp1) w_next = ST_DONE;
          else if (w_en_clr) w_next = ST_CLR;
          else if (w_en_cmp) w_next = ST_CMP;
          else if (w_en_inc) w_next = ST_INC;
          else if (w_en_rot) w_next = ST_ROT;
          else w_next = ST_DONE;
        end
      end
      ST_CLR: begin
        busy = 1'b1;
        if (w_en_cmp) w_next = ST_CMP;
        else if (w_en_inc) w_next = ST_INC;
        else if (w_en_rot) w_next = ST_ROT;
        else w_next = ST_DONE;
      end
      ST_CMP: begin
        busy = 1'b1;
        if (w_en_inc) w_next = ST_INC;
        else if (w_en_rot) w_next = ST_ROT;
        else w_next = ST_DONE;
      end
      ST_INC: begin
        busy   = 1'b1;
        w_next = w_en_rot ? ST_ROT : ST_DONE;
      end
      ST_ROT: begin
        busy   = 1'b1;
        ROE    = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ac    <= '0;
      r_l     <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ac <= ACI;
            r_l  <= LI;
          end
        end
        ST_CLR: begin
          if (w_ctl.cla) r_ac <= '0;
          if (w_ctl.cll) r_l  <= 1'b0;
        end
        ST_CMP: begin
          if (w_ctl.cma) r_ac <= ~r_ac;
          if (w_ctl.cml) r_l  <= ~r_l;
        end
        ST_INC: begin
          // 13-bit increment: carry out of AC toggles the link.
          if (w_ctl.iac) {r_l, r_ac} <= {r_l, r_ac} + 13'd1;
        end
        ST_ROT: begin
          r_ac <= RAO;
          r_l  <= RLO;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && start)
      r_ir <= IR;
  end

  assign ACO = r_ac;
  assign LO  = r_l;
  assign RAI = r_ac;
  assign RLI = r_l;
  assign ROP = w_ctl.rop;

endmodule

// File: tb/tb_opr1_sequencer.sv
// Scoreboard bench for opr1_sequencer with a behavioural rotater and reference model.
module tb_opr1_sequencer;

  typedef struct {
    logic [11:0] ac;
    logic        l;
    int          lat;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] IR;
  logic [11:0] ACI;
  logic        LI;
  logic [11:0] ACO;
  logic        LO;
  logic        busy;
  logic        done;
  logic [2:0]  ROP;
  logic [11:0] RAI;
  logic        RLI;
  logic        ROE;
  logic [11:0] RAO;
  logic        RLO;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [2:0]  cur_rop = 3'b000;
  exp_t        q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  opr1_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .IR    (IR),
    .ACI   (ACI),
    .LI    (LI),
    .ACO   (ACO),
    .LO    (LO),
    .busy  (busy),
    .done  (done),
    .ROP   (ROP),
    .RAI   (RAI),
    .RLI   (RLI),
    .ROE   (ROE),
    .RAO   (RAO),
    .RLO   (RLO)
  );

  // Rotate the 13-bit link:accumulator ring, or swap the 6-bit AC halves.
  function automatic logic [12:0] rot13(input logic [2:0] op, input logic l, input logic [11:0] a);
    logic [12:0] v;
    v = {l, a};
    case (op)
      3'b001:  return {l, a[5:0], a[11:6]};
      3'b010:  return {v[11:0], v[12]};
      3'b011:  return {v[10:0], v[12:11]};
      3'b100:  return {v[0], v[12:1]};
      3'b101:  return {v[1:0], v[12:2]};
      default: return v;
    endcase
  endfunction

  always_comb {RLO, RAO} = rot13(ROP, RLI, RAI);

  function automatic logic [2:0] exp_rop(input logic [11:0] ir);
    logic rar, ral, bsw;
    rar = ir[3]; ral = ir[2]; bsw = ir[1];
    if (rar && ral) return 3'b000;
    if (ral)        return bsw ? 3'b011 : 3'b010;
    if (rar)        return bsw ? 3'b101 : 3'b100;
    if (bsw)        return 3'b001;
    return 3'b000;
  endfunction

  function automatic exp_t model(input logic [11:0] ir, input logic [11:0] aci, input logic li);
    exp_t        e;
    int          ac, l, v, steps;
    logic [2:0]  r;
    logic [12:0] rv;
    e.t0 = 0;
    if (ir[11:8] != 4'b1110) begin
      e.ac = aci; e.l = li; e.lat = 1;
      return e;
    end
    ac = int'(aci); l = int'(li);
    if (ir[7]) ac = 0;
    if (ir[6]) l = 0;
    if (ir[5]) ac = 4095 - ac;
    if (ir[4]) l = 1 - l;
    if (ir[0]) begin
      v  = (l * 4096 + ac + 1) % 8192;
      l  = v / 4096;
      ac = v % 4096;
    end
    r  = exp_rop(ir);
    rv = rot13(r, l[0], ac[11:0]);
    e.l  = rv[12];
    e.ac = rv[11:0];
`ifdef OPR1_FASTSEQ_EN
    steps = int'(ir[7] | ir[6]) + int'(ir[5] | ir[4]) + int'(ir[0]) + int'(r != 3'b000);
`else
    steps = 4;
`endif
    e.lat = 1 + steps;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || done) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy || done) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout busy=%0b done=%0b required idle", busy, done);
    end
  endtask

  task automatic issue(input logic [11:0] ir, input logic [11:0] aci, input logic li, input bit spam);
    exp_t e;
    wait_idle();
    IR = ir; ACI = aci; LI = li; start = 1'b1;
    e = model(ir, aci, li);
    e.t0 = cyc;
    q.push_back(e);
    cur_rop = exp_rop(ir);
    @(posedge clk); #1;
    start = 1'b0;
    if (spam) begin
      start = 1'b1;
      IR  = 12'($urandom);
      ACI = 12'($urandom);
      LI  = 1'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ROE) chk("rop_in_rot", 32'(ROP), 32'(cur_rop));
    if (done) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("aco", 32'(ACO), 32'(e.ac));
        chk("lo", 32'(LO), 32'(e.l));
        chk("done_latency", 32'(cyc - e.t0), 32'(e.lat));
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    logic [11:0] ir;
    reset = 1'b1; start = 1'b0; IR = '0; ACI = '0; LI = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_aco", 32'(ACO), 32'd0);
    chk("rst_lo", 32'(LO), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue(12'o7001, 12'o7777, 1'b0, 1'b0);
    issue(12'o7240, 12'o1234, 1'b1, 1'b0);
    issue(12'o7240, 12'o1234, 1'b0, 1'b0);
    issue(12'o7104, 12'o4000, 1'b1, 1'b0);
    issue(12'o7012, 12'o0001, 1'b0, 1'b0);
    issue(12'o7002, 12'o0077, 1'b0, 1'b0);
    issue(12'o7400, 12'o5252, 1'b1, 1'b0);
    issue(12'o7000, 12'o3141, 1'b1, 1'b0);
    issue(12'o7001, 12'o0123, 1'b0, 1'b1);
    issue(12'o7400, 12'o0456, 1'b0, 1'b1);

    // Reset while in INC: AC holds 7777 there, must clear and never finish.
    wait_idle();
    IR = 12'o7245; ACI = 12'o1357; LI = 1'b1; start = 1'b1;
    cur_rop = exp_rop(12'o7245);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_aco", 32'(ACO), 32'd0);
    chk("midrst_lo", 32'(LO), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < 150; i++) begin
      ir = 12'($urandom);
      if ($urandom_range(0, 3) != 0) ir[11:8] = 4'b1110;
      issue(ir, 12'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
